// File: rtl/camera_pkg.sv
// Shared types and default parameters for the camera readout slice.
// Optional build macro: PROTO_CHECK_EN (adds the proto_err port to camera_readout).
package camera_pkg;

    // Readout sequencing states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ERASE  = 2'd1,
        EXPOSE = 2'd2,
        READ   = 2'd3
    } cam_state_t;

    localparam int DEF_COLS       = 2;
    localparam int DEF_ADC_W      = 8;
    localparam int DEF_EXP_W      = 5;
    localparam int DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/camera_pix_fifo.sv
// Synchronous pixel FIFO: writes COLS entries per push, reads one entry per pop.
// Head entry is presented straight from the storage registers; flush empties it.
module camera_pix_fifo #(
    parameter int ENTRY_W = 11,
    parameter int COLS    = 2,
    parameter int DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          push,
    input  logic [COLS*ENTRY_W-1:0]       push_data,
    input  logic                          pop,
    output logic [ENTRY_W-1:0]            head,
    output logic [$clog2(DEPTH+1)-1:0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ENTRY_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_nxt_s;

    // Occupancy after this cycle's push and pop
    always_comb begin
        count_nxt_s = count_r;
        if (push && pop) begin
            count_nxt_s = count_r + CNT_W'(COLS) - CNT_W'(1);
        end else if (push) begin
            count_nxt_s = count_r + CNT_W'(COLS);
        end else if (pop) begin
            count_nxt_s = count_r - CNT_W'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Storage, pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {ENTRY_W{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push) begin
                for (int i = 0; i < COLS; i++) begin
                    mem_r[wr_ptr_r + PTR_W'(i)] <= push_data[i*ENTRY_W +: ENTRY_W];
                end
                wr_ptr_r <= wr_ptr_r + PTR_W'(COLS);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_nxt_s;
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/camera_readout.sv
// Receive side of the camera_control sensor interface: sequences erase/expose/read,
// captures two ADC rows per frame into a pixel FIFO and streams them row-major.
// Optional build macro: PROTO_CHECK_EN adds a sticky proto_err output.
module camera_readout
    import camera_pkg::*;
#(
    parameter int COLS       = DEF_COLS,
    parameter int ADC_W      = DEF_ADC_W,
    parameter int EXP_W      = DEF_EXP_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      erase,
    input  logic                      expose,
    input  logic                      nre1,
    input  logic                      nre2,
    input  logic                      adc,
    input  logic [COLS*ADC_W-1:0]     adc_data,
    output logic [ADC_W-1:0]          pix_data,
    output logic                      pix_row,
    output logic [$clog2(COLS)-1:0]   pix_col,
    output logic                      pix_last,
    output logic                      pix_valid,
    input  logic                      pix_ready,
    output logic                      frame_done,
    output logic [EXP_W-1:0]          exp_cycles,
    output logic                      overflow
`ifdef PROTO_CHECK_EN
    ,
    output logic                      proto_err
`endif
);

    localparam int CW      = $clog2(COLS);
    localparam int ENTRY_W = ADC_W + CW + 2;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

    cam_state_t            state_r;
    cam_state_t            state_nxt_s;
    logic                  adc_q_r;
    logic                  row0_done_r;
    logic [EXP_W-1:0]      exp_cnt_r;
    logic [EXP_W-1:0]      exp_cycles_r;
    logic                  overflow_r;
    logic                  frame_done_r;

    logic                  cap_s;
    logic                  row0_cap_s;
    logic                  row1_cap_s;
    logic                  room_s;
    logic                  push_s;
    logic                  drop_s;
    logic                  pop_s;
    logic                  valid_s;
    logic [COLS*ENTRY_W-1:0] push_data_s;
    logic [ENTRY_W-1:0]    head_s;
    logic [CNT_W-1:0]      count_s;

    function automatic logic [EXP_W-1:0] sat_inc(input logic [EXP_W-1:0] v);
        sat_inc = (v == {EXP_W{1'b1}}) ? v : v + EXP_W'(1);
    endfunction

    // A capture only counts on the rising edge of the ADC strobe
    assign cap_s      = adc & ~adc_q_r;
    // Row 1 may be re-read any time in READ; row 2 only after a row 1 read
    assign row0_cap_s = (state_r == READ) & cap_s & ~nre1 & nre2 & ~erase;
    assign row1_cap_s = (state_r == READ) & cap_s & nre1 & ~nre2 & row0_done_r & ~erase;
    // Room is judged on occupancy before any same-cycle pop
    assign room_s     = (count_s <= CNT_W'(FIFO_DEPTH - COLS));
    assign push_s     = (row0_cap_s | row1_cap_s) & room_s;
    assign drop_s     = (row0_cap_s | row1_cap_s) & ~room_s;
    assign valid_s    = (count_s != {CNT_W{1'b0}});
    assign pop_s      = valid_s & pix_ready;

    // Pack one row into COLS FIFO entries {last, row, col, data}, column 0 first
    always_comb begin
        push_data_s = {(COLS*ENTRY_W){1'b0}};
        for (int c = 0; c < COLS; c++) begin
            push_data_s[c*ENTRY_W +: ENTRY_W] = {(row1_cap_s && (c == COLS - 1)),
                                                 row1_cap_s,
                                                 CW'(c),
                                                 adc_data[c*ADC_W +: ADC_W]};
        end
    end

    camera_pix_fifo #(
        .ENTRY_W (ENTRY_W),
        .COLS    (COLS),
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (erase),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .head      (head_s),
        .count     (count_s)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state; erase overrides everything
    always_comb begin
        state_nxt_s = state_r;
        if (erase) begin
            state_nxt_s = ERASE;
        end else begin
            case (state_r)
                IDLE:    state_nxt_s = IDLE;
                ERASE:   state_nxt_s = expose ? EXPOSE : ERASE;
                EXPOSE:  state_nxt_s = expose ? EXPOSE : READ;
                READ:    state_nxt_s = row1_cap_s ? IDLE : READ;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // Strobe history, exposure measurement, row tracking and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            adc_q_r      <= 1'b0;
            row0_done_r  <= 1'b0;
            exp_cnt_r    <= {EXP_W{1'b0}};
            exp_cycles_r <= {EXP_W{1'b0}};
            overflow_r   <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            adc_q_r      <= adc;
            frame_done_r <= row1_cap_s;
            if (erase) begin
                row0_done_r <= 1'b0;
                exp_cnt_r   <= {EXP_W{1'b0}};
                overflow_r  <= 1'b0;
            end else begin
                if (drop_s) begin
                    overflow_r <= 1'b1;
                end
                case (state_r)
                    ERASE: begin
                        if (expose) begin
                            exp_cnt_r <= EXP_W'(1);
                        end
                    end
                    EXPOSE: begin
                        if (expose) begin
                            exp_cnt_r <= sat_inc(exp_cnt_r);
                        end else begin
                            exp_cycles_r <= exp_cnt_r;
                            row0_done_r  <= 1'b0;
                        end
                    end
                    READ: begin
                        if (row0_cap_s) begin
                            row0_done_r <= 1'b1;
                        end
                    end
                    default: begin
                        row0_done_r <= row0_done_r;
                    end
                endcase
            end
        end
    end

`ifdef PROTO_CHECK_EN
    logic proto_viol_s;
    logic proto_err_r;

    assign proto_viol_s = (cap_s & (nre1 == nre2))
                        | (cap_s & (state_r != READ))
                        | (expose & (state_r == READ))
                        | (~nre1 & ~nre2)
                        | ((state_r == READ) & cap_s & nre1 & ~nre2 & ~row0_done_r);

    // Sticky interface-misuse flag, cleared by reset or erase
    always_ff @(posedge clk) begin
        if (reset || erase) begin
            proto_err_r <= 1'b0;
        end else if (proto_viol_s) begin
            proto_err_r <= 1'b1;
        end else begin
            proto_err_r <= proto_err_r;
        end
    end

    assign proto_err = proto_err_r;
`endif

    // Present the FIFO head; fields read as zero while nothing is queued
    always_comb begin
        pix_data = {ADC_W{1'b0}};
        pix_col  = {CW{1'b0}};
        pix_row  = 1'b0;
        pix_last = 1'b0;
        if (valid_s) begin
            pix_data = head_s[ADC_W-1:0];
            pix_col  = head_s[ADC_W +: CW];
            pix_row  = head_s[ADC_W + CW];
            pix_last = head_s[ADC_W + CW + 1];
        end else begin
            pix_data = {ADC_W{1'b0}};
        end
    end

    assign pix_valid  = valid_s;
    assign frame_done = frame_done_r;
    assign exp_cycles = exp_cycles_r;
    assign overflow   = overflow_r;

endmodule
